// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN-scheduled elevator car controller with request latching,
// tick-timed travel and door dwell, and capacity-limited occupancy tracking.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   tick     one-cycle timing strobe; travel and door timers advance only on it
//   req      floor request buttons (level), bit i = floor i
//   add      one-cycle pulse, a person enters (honoured only while door open)
//   rem      one-cycle pulse, a person leaves (honoured only while door open)
//   close    one-cycle pulse, close the door early
//   floor    current floor
//   dir      travel direction, 1 = up, 0 = down
//   door     1 while the door is open
//   people   current occupancy
//   pending  latched outstanding requests
//   moving   1 while travelling between floors
//   full     occupancy equals capacity
module elevator_ctrl #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3,
    parameter int MAX_PEOPLE = 7,
    parameter int PEOPLE_W   = 3,
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  add,
    input  logic                  rem,
    input  logic                  close,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir,
    output logic                  door,
    output logic [PEOPLE_W-1:0]   people,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving,
    output logic                  full
);

    localparam int MW = $clog2(MOVE_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

    state_t                state, state_nx;
    logic [FLOOR_W-1:0]    floor_nx;
    logic                  dir_nx;
    logic [MW-1:0]         move_cnt, move_nx;
    logic [DW-1:0]         door_cnt, door_nx;
    logic [PEOPLE_W-1:0]   people_nx;
    logic [NUM_FLOORS-1:0] pending_nx, req_q, here, here_nx;
    logic                  here_rise;

    // Any pending request strictly beyond floor f in direction d.
    function automatic logic look(input logic [NUM_FLOORS-1:0] p,
                                  input logic [FLOOR_W-1:0] f, input logic d);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (p[i] && (d ? i > int'(f) : i < int'(f))) r = 1'b1;
        return r;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] o;
        for (int i = 0; i < NUM_FLOORS; i++) o[i] = (int'(f) == i);
        return o;
    endfunction

    assign door   = (state == DOOR_OPEN);
    assign moving = (state == MOVING);
    assign full   = (people == PEOPLE_W'(MAX_PEOPLE));
    assign here   = onehot(floor);
    assign here_nx = onehot(floor_nx);
    // A fresh press of the open floor's button holds the door.
    assign here_rise = |(req & ~req_q & here);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            floor    <= '0;
            dir      <= 1'b1;
            move_cnt <= '0;
            door_cnt <= '0;
            people   <= '0;
            pending  <= '0;
            req_q    <= '0;
        end else begin
            state    <= state_nx;
            floor    <= floor_nx;
            dir      <= dir_nx;
            move_cnt <= move_nx;
            door_cnt <= door_nx;
            people   <= people_nx;
            pending  <= pending_nx;
            req_q    <= req;
        end
    end

    always_comb begin
        state_nx   = state;
        floor_nx   = floor;
        dir_nx     = dir;
        move_nx    = move_cnt;
        door_nx    = door_cnt;
        people_nx  = people;
        pending_nx = (pending | req) & ~(door ? here : {NUM_FLOORS{1'b0}});
        if (door && add && !rem && people != PEOPLE_W'(MAX_PEOPLE))
            people_nx = people + 1'b1;
        if (door && rem && !add && people != '0)
            people_nx = people - 1'b1;
        case (state)
            IDLE: begin
                if (|(pending & here)) begin
                    state_nx = DOOR_OPEN;
                    door_nx  = '0;
                end else if (look(pending, floor, dir)) begin
                    state_nx = MOVING;
                end else if (look(pending, floor, ~dir)) begin
                    state_nx = MOVING;
                    dir_nx   = ~dir;
                end
            end
            MOVING: begin
                if (tick) begin
                    if (move_cnt == MW'(MOVE_TICKS - 1)) begin
                        move_nx  = '0;
                        floor_nx = dir ? floor + 1'b1 : floor - 1'b1;
                        if (|(pending & here_nx)) begin
                            state_nx = DOOR_OPEN;
                            door_nx  = '0;
                        end else if (!look(pending, floor_nx, dir)) begin
                            state_nx = IDLE;
                        end
                    end else begin
                        move_nx = move_cnt + 1'b1;
                    end
                end
            end
            DOOR_OPEN: begin
                if (close) begin
                    state_nx = IDLE;
                    door_nx  = '0;
                end else if (here_rise) begin
                    door_nx = '0;
                end else if (tick) begin
                    if (door_cnt == DW'(DOOR_TICKS - 1)) begin
                        state_nx = IDLE;
                        door_nx  = '0;
                    end else begin
                        door_nx = door_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed vector table plus multi-cycle sequences for elevator_ctrl.
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] req = '0;
    logic [3:0] req4 = '0;
    logic       add = 1'b0, rem = 1'b0, close = 1'b0;
    logic [2:0] floor, people;
    logic       dir, door, moving, full;
    logic [7:0] pending;
    logic [1:0] f4;
    logic       d4, dr4, m4, fu4;
    logic [2:0] p4;
    logic [3:0] pd4;

    int checks = 0;
    int errors = 0;

    elevator_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .add(add), .rem(rem),
        .close(close), .floor(floor), .dir(dir), .door(door), .people(people),
        .pending(pending), .moving(moving), .full(full)
    );

    elevator_ctrl #(.NUM_FLOORS(4), .FLOOR_W(2)) u4 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req4), .add(add), .rem(rem),
        .close(close), .floor(f4), .dir(d4), .door(dr4), .people(p4),
        .pending(pd4), .moving(m4), .full(fu4)
    );

    always #5 clk = ~clk;

    // fl = {dir, door, moving, full}; pl = {add, rem, close}
    typedef struct {
        int         n;
        logic       tk;
        logic [7:0] rq;
        logic [2:0] pl;
        logic [2:0] f;
        logic [3:0] fl;
        logic [2:0] p;
        logic [7:0] pd;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return {14'b0, floor, dir, door, moving, full, people, pending};
    endfunction

    initial begin
        int kd, max4;
        logic [2:0] f_at, f_prev;
        logic [7:0] pd_after;
        logic mono, d58, d59, seen4;

        v.push_back('{1,  1'b0, 8'h20, 3'b000, 3'd0, 4'b1000, 3'd0, 8'h20});
        v.push_back('{1,  1'b0, 8'h00, 3'b000, 3'd0, 4'b1010, 3'd0, 8'h20});
        v.push_back('{1,  1'b1, 8'h00, 3'b000, 3'd0, 4'b1010, 3'd0, 8'h20});
        v.push_back('{1,  1'b1, 8'h00, 3'b000, 3'd1, 4'b1010, 3'd0, 8'h20});
        v.push_back('{8,  1'b1, 8'h00, 3'b000, 3'd5, 4'b1100, 3'd0, 8'h20});
        v.push_back('{1,  1'b0, 8'h00, 3'b000, 3'd5, 4'b1100, 3'd0, 8'h00});
        v.push_back('{1,  1'b0, 8'h84, 3'b000, 3'd5, 4'b1100, 3'd0, 8'h84});
        v.push_back('{5,  1'b1, 8'h00, 3'b000, 3'd5, 4'b1000, 3'd0, 8'h84});
        v.push_back('{1,  1'b0, 8'h00, 3'b000, 3'd5, 4'b1010, 3'd0, 8'h84});
        v.push_back('{4,  1'b1, 8'h00, 3'b000, 3'd7, 4'b1100, 3'd0, 8'h84});
        v.push_back('{1,  1'b1, 8'h00, 3'b001, 3'd7, 4'b1000, 3'd0, 8'h04});
        v.push_back('{1,  1'b0, 8'h00, 3'b000, 3'd7, 4'b0010, 3'd0, 8'h04});
        v.push_back('{10, 1'b1, 8'h00, 3'b000, 3'd2, 4'b0100, 3'd0, 8'h04});
        v.push_back('{1,  1'b0, 8'h00, 3'b000, 3'd2, 4'b0100, 3'd0, 8'h00});
        v.push_back('{9,  1'b0, 8'h00, 3'b100, 3'd2, 4'b0101, 3'd7, 8'h00});
        v.push_back('{1,  1'b0, 8'h00, 3'b110, 3'd2, 4'b0101, 3'd7, 8'h00});
        v.push_back('{8,  1'b0, 8'h00, 3'b010, 3'd2, 4'b0100, 3'd0, 8'h00});
        v.push_back('{2,  1'b0, 8'h00, 3'b100, 3'd2, 4'b0100, 3'd2, 8'h00});
        v.push_back('{3,  1'b1, 8'h00, 3'b000, 3'd2, 4'b0100, 3'd2, 8'h00});
        v.push_back('{1,  1'b1, 8'h00, 3'b001, 3'd2, 4'b0000, 3'd2, 8'h00});
        v.push_back('{1,  1'b0, 8'h00, 3'b100, 3'd2, 4'b0000, 3'd2, 8'h00});
        v.push_back('{1,  1'b0, 8'h08, 3'b000, 3'd2, 4'b0000, 3'd2, 8'h08});
        v.push_back('{1,  1'b0, 8'h00, 3'b000, 3'd2, 4'b1010, 3'd2, 8'h08});
        v.push_back('{2,  1'b1, 8'h00, 3'b000, 3'd3, 4'b1100, 3'd2, 8'h08});
        v.push_back('{1,  1'b0, 8'h00, 3'b000, 3'd3, 4'b1100, 3'd2, 8'h00});
        v.push_back('{4,  1'b1, 8'h00, 3'b000, 3'd3, 4'b1100, 3'd2, 8'h00});
        v.push_back('{1,  1'b0, 8'h08, 3'b000, 3'd3, 4'b1100, 3'd2, 8'h00});
        v.push_back('{4,  1'b1, 8'h00, 3'b000, 3'd3, 4'b1100, 3'd2, 8'h00});
        v.push_back('{1,  1'b1, 8'h00, 3'b000, 3'd3, 4'b1000, 3'd2, 8'h00});
        v.push_back('{1,  1'b0, 8'h80, 3'b000, 3'd3, 4'b1000, 3'd2, 8'h80});
        v.push_back('{1,  1'b0, 8'h00, 3'b000, 3'd3, 4'b1010, 3'd2, 8'h80});
        v.push_back('{2,  1'b1, 8'h00, 3'b000, 3'd4, 4'b1010, 3'd2, 8'h80});

        repeat (3) @(posedge clk);
        #1;
        chk("reset", snap(), {14'b0, 3'd0, 4'b1000, 3'd0, 8'h00});
        rst_n = 1'b1;

        foreach (v[r]) begin
            for (int c = 0; c < v[r].n; c++) begin
                tick = v[r].tk;
                req = v[r].rq;
                {add, rem, close} = v[r].pl;
                @(posedge clk);
                #1;
            end
            tick = 1'b0;
            req = '0;
            {add, rem, close} = 3'b000;
            chk($sformatf("row%0d", r), snap(), {14'b0, v[r].f, v[r].fl, v[r].p, v[r].pd});
        end

        #2 rst_n = 1'b0;
        #1 chk("async_reset", snap(), {14'b0, 3'd0, 4'b1000, 3'd0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;

        // Travel to floor 5 with a tick every 4 clocks.
        req = 8'h20;
        @(posedge clk);
        #1;
        req = '0;
        kd = -1;
        f_at = '0;
        f_prev = '0;
        pd_after = 8'hff;
        mono = 1'b1;
        d58 = 1'b0;
        d59 = 1'b1;
        for (int k = 0; k < 80; k++) begin
            tick = (k % 4 == 3);
            @(posedge clk);
            #1;
            tick = 1'b0;
            if (floor < f_prev || floor > f_prev + 3'd1) mono = 1'b0;
            f_prev = floor;
            if (kd < 0 && door) begin
                kd = k;
                f_at = floor;
            end
            if (kd >= 0 && k == kd + 1) pd_after = pending;
            if (k == 58) d58 = door;
            if (k == 59) d59 = door;
        end
        chk("slow_arrive_cycle", kd, 39);
        chk("slow_arrive_floor", f_at, 5);
        chk("slow_pending_clear", pd_after, 8'h00);
        chk("slow_monotonic", mono, 1);
        chk("slow_door_held", d58, 1);
        chk("slow_door_closed", d59, 0);

        // Four-floor car: a top-floor request stops at floor 3.
        req4 = 4'b1000;
        @(posedge clk);
        #1;
        req4 = '0;
        max4 = 0;
        seen4 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            if (int'(f4) > max4) max4 = int'(f4);
            if (dr4 && f4 == 2'd3) seen4 = 1'b1;
        end
        tick = 1'b0;
        chk("f4_max_floor", max4, 3);
        chk("f4_door_at_top", seen4, 1);
        chk("f4_final", {f4, dr4, m4, pd4}, {2'd3, 1'b0, 1'b0, 4'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
